mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 11 +
 rtl/arb_wait_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and parameter defaults.
package mips_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEF     = 15;
  localparam int D_BURST_MAX_DEF = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// Counts BUSY cycles spent waiting on mem_ready; flags the cycle that exhausts the budget.
module arb_wait_counter
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 8'd1;
  end

  // Fires in the TIMEOUT-th waiting cycle so mem_en is high exactly TIMEOUT cycles.
  assign expired = inc && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory, with data
// priority bounded by a burst limit and a per-access timeout.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int D_BURST_MAX = D_BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        if_stall,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);
  localparam int BW = $clog2(D_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX_V = BW'(D_BURST_MAX);

  arb_state_e  state_q, state_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d, d_done_q, d_done_d;
  logic        err_q, err_d;
  logic [BW-1:0] burst_q, burst_d;

  logic busy, expired, finish, gnt_data, gnt_fetch;

  assign busy      = (state_q != IDLE);
  assign finish    = busy && (mem_ready || expired);
  assign gnt_data  = (state_q == IDLE) && d_req && (!if_req || (burst_q < BURST_MAX_V));
  assign gnt_fetch = (state_q == IDLE) && if_req && !gnt_data;

  arb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (gnt_data || gnt_fetch),
    .inc     (busy && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = err_q || expired;
    burst_d     = burst_q;

    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          state_d     = D_BUSY;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (gnt_fetch) begin
          state_d     = IF_BUSY;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      IF_BUSY: if (finish) begin
        state_d    = IDLE;
        if_done_d  = 1'b1;
        if_rdata_d = mem_ready ? mem_rdata : '0;
      end
      D_BUSY: if (finish) begin
        state_d  = IDLE;
        d_done_d = 1'b1;
        // Stores leave d_rdata alone, including when they time out.
        if (!mem_we_q) d_rdata_d = mem_ready ? mem_rdata : '0;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end

    if (!if_req || gnt_fetch)                  burst_d = '0;
    else if (gnt_data && burst_q < BURST_MAX_V) burst_d = burst_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      burst_q     <= burst_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign if_stall  = if_req && !if_done_q;
  assign d_stall   = d_req && !d_done_q;
endmodule
